// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ADJ   = 2'd3
    } state_t;

    localparam int MAX_TOTALSEC = 5999;
    localparam int MAX_MIN      = 99;
    localparam int MAX_SEC      = 59;

    // Counter width for a divider cycling 0..period-1; never narrower than one bit.
    function automatic int div_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_pulse_div.sv
// Terminal-count divider: counts 0..PERIOD-1 while enabled, sync clear, pulse on terminal count.
module stopwatch_pulse_div
    import stopwatch_pkg::*;
#(
    parameter int PERIOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic pulse
);

    localparam int           W  = div_width(PERIOD);
    localparam logic [W-1:0] TC = W'(PERIOD - 1);

    logic [W-1:0] cnt;

    assign pulse = en & ~clr & (cnt == TC);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TC) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button edges to run/pause/clear/adjust commands and timing pulses.
// Optional lap-hold feature is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int ADJ_HZ   = 2,
    parameter int BLINK_HZ = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pause,
    input  logic btn_clr,
    input  logic adj,
    input  logic sel,
    input  logic at_max,
`ifdef STOPWATCH_LAP_EN
    input  logic btn_lap,
    output logic lap_hold,
`endif
    output logic cnt_en,
    output logic cnt_clr,
    output logic adj_sec,
    output logic adj_min,
    output logic running,
    output logic blink
);

    localparam int TICK_PERIOD  = CLK_HZ;
    localparam int ADJ_PERIOD   = CLK_HZ / ADJ_HZ;
    localparam int BLINK_PERIOD = CLK_HZ / (2 * BLINK_HZ);

    state_t state_q;
    state_t state_d;

    logic pause_prev;
    logic clr_prev;
    logic sel_prev;
    logic pause_edge;
    logic clr_edge;

    logic tick_pulse;
    logic adj_pulse;
    logic blink_pulse;

    assign pause_edge = btn_pause & ~pause_prev;
    assign clr_edge   = btn_clr & ~clr_prev;

    // A pause edge outside ADJ is always consumed, so adj/at_max are only looked at without one.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (clr_edge) begin
            state_d = ST_IDLE;
        end else if (pause_edge && state_q != ST_ADJ) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = at_max ? ST_PAUSE : ST_RUN;
                default:  state_d = state_q;
            endcase
        end else begin
            case (state_q)
                ST_IDLE:  if (adj) state_d = ST_ADJ;
                ST_PAUSE: if (adj) state_d = ST_ADJ;
                ST_ADJ:   if (!adj) state_d = ST_PAUSE;
                ST_RUN:   if (at_max) state_d = ST_PAUSE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // PAUSE neither counts nor clears the tick divider, so a resume finishes the partial second.
    stopwatch_pulse_div #(.PERIOD(TICK_PERIOD)) u_tick_div (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == ST_RUN),
        .clr   (clr_edge | (state_q == ST_IDLE) | (state_q == ST_ADJ)),
        .pulse (tick_pulse)
    );

    stopwatch_pulse_div #(.PERIOD(ADJ_PERIOD)) u_adj_div (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == ST_ADJ),
        .clr   (clr_edge | (state_q != ST_ADJ) | (sel != sel_prev)),
        .pulse (adj_pulse)
    );

    stopwatch_pulse_div #(.PERIOD(BLINK_PERIOD)) u_blink_div (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == ST_ADJ),
        .clr   (clr_edge | (state_q != ST_ADJ)),
        .pulse (blink_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pause_prev <= 1'b0;
            clr_prev   <= 1'b0;
            sel_prev   <= 1'b0;
            cnt_en     <= 1'b0;
            cnt_clr    <= 1'b0;
            adj_sec    <= 1'b0;
            adj_min    <= 1'b0;
            running    <= 1'b0;
            blink      <= 1'b1;
        end else begin
            state_q    <= state_d;
            pause_prev <= btn_pause;
            clr_prev   <= btn_clr;
            sel_prev   <= sel;
            cnt_en     <= tick_pulse & ~at_max;
            cnt_clr    <= clr_edge;
            adj_sec    <= adj_pulse & ~sel;
            adj_min    <= adj_pulse & sel;
            running    <= (state_d == ST_RUN);
            blink      <= (state_d != ST_ADJ) | (blink ^ blink_pulse);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_prev;
    logic lap_edge;

    assign lap_edge = btn_lap & ~lap_prev;

    // Lap only toggles while already in RUN; anything that leaves RUN drops the hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_prev <= 1'b0;
            lap_hold <= 1'b0;
        end else begin
            lap_prev <= btn_lap;
            lap_hold <= (state_d == ST_RUN) & ~clr_edge
                      & (lap_hold ^ (lap_edge & (state_q == ST_RUN)));
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed timing scenarios plus randomized stimulus
// against a cycle-level behavioural model. Lap checks are active when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_ctrl;

    localparam int CLK_HZ   = 10;
    localparam int ADJ_HZ   = 2;
    localparam int BLINK_HZ = 1;

    localparam int SEC_CYC   = CLK_HZ;
    localparam int ADJ_CYC   = CLK_HZ / ADJ_HZ;
    localparam int BLINK_CYC = CLK_HZ / (2 * BLINK_HZ);

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ADJ   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_pause = 1'b0;
    logic btn_clr = 1'b0;
    logic adj = 1'b0;
    logic sel = 1'b0;
    logic at_max = 1'b0;
    logic btn_lap = 1'b0;
    logic lap_hold;
    logic cnt_en, cnt_clr, adj_sec, adj_min, running, blink;

    stopwatch_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .ADJ_HZ   (ADJ_HZ),
        .BLINK_HZ (BLINK_HZ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pause (btn_pause),
        .btn_clr   (btn_clr),
        .adj       (adj),
        .sel       (sel),
        .at_max    (at_max),
`ifdef STOPWATCH_LAP_EN
        .btn_lap   (btn_lap),
        .lap_hold  (lap_hold),
`endif
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .adj_sec   (adj_sec),
        .adj_min   (adj_min),
        .running   (running),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: mode, elapsed cycles in the current second / adjust step / blink phase.
    int m_mode = M_IDLE;
    int m_sec_elapsed = 0;
    int m_adj_elapsed = 0;
    int m_blink_elapsed = 0;
    bit m_prev_pause = 0, m_prev_clr = 0, m_prev_lap = 0, m_prev_sel = 0;
    bit e_cnt_en = 0, e_cnt_clr = 0, e_adj_sec = 0, e_adj_min = 0;
    bit e_running = 0, e_blink = 1, e_lap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit pe, ce, le, sec_done, adj_done, blink_done;
        int nm;
        if (rst) begin
            m_mode = M_IDLE;
            m_sec_elapsed = 0;
            m_adj_elapsed = 0;
            m_blink_elapsed = 0;
            m_prev_pause = 0; m_prev_clr = 0; m_prev_lap = 0; m_prev_sel = 0;
            e_cnt_en = 0; e_cnt_clr = 0; e_adj_sec = 0; e_adj_min = 0;
            e_running = 0; e_blink = 1; e_lap = 0;
            return;
        end
        pe = btn_pause && !m_prev_pause;
        ce = btn_clr && !m_prev_clr;
        le = btn_lap && !m_prev_lap;
        sec_done   = (m_mode == M_RUN) && !ce && (m_sec_elapsed == SEC_CYC - 1);
        adj_done   = (m_mode == M_ADJ) && !ce && (sel == m_prev_sel) && (m_adj_elapsed == ADJ_CYC - 1);
        blink_done = (m_mode == M_ADJ) && !ce && (m_blink_elapsed == BLINK_CYC - 1);

        nm = m_mode;
        if (ce) nm = M_IDLE;
        else if (pe && m_mode != M_ADJ) begin
            if (m_mode == M_IDLE) nm = M_RUN;
            else if (m_mode == M_RUN) nm = M_PAUSE;
            else nm = at_max ? M_PAUSE : M_RUN;
        end
        else if (m_mode == M_ADJ) nm = adj ? M_ADJ : M_PAUSE;
        else if (m_mode == M_RUN) nm = at_max ? M_PAUSE : M_RUN;
        else if (adj) nm = M_ADJ;

        e_cnt_en  = sec_done && !at_max;
        e_cnt_clr = ce;
        e_adj_sec = adj_done && !sel;
        e_adj_min = adj_done && sel;
        e_running = (nm == M_RUN);
        e_blink   = (nm != M_ADJ) ? 1'b1 : (e_blink ^ blink_done);
        e_lap     = (nm == M_RUN && !ce) ? (e_lap ^ (le && m_mode == M_RUN)) : 1'b0;

        if (ce || m_mode == M_IDLE || m_mode == M_ADJ) m_sec_elapsed = 0;
        else if (m_mode == M_RUN) m_sec_elapsed = (m_sec_elapsed + 1) % SEC_CYC;
        if (ce || m_mode != M_ADJ || sel != m_prev_sel) m_adj_elapsed = 0;
        else m_adj_elapsed = (m_adj_elapsed + 1) % ADJ_CYC;
        if (ce || m_mode != M_ADJ) m_blink_elapsed = 0;
        else m_blink_elapsed = (m_blink_elapsed + 1) % BLINK_CYC;

        m_mode = nm;
        m_prev_pause = btn_pause;
        m_prev_clr = btn_clr;
        m_prev_lap = btn_lap;
        m_prev_sel = sel;
    endtask

    // One clock: model advances with the inputs sampled at this edge, outputs compared 1 ns later.
    task automatic step();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("cnt_en",  cnt_en,  e_cnt_en);
        check("cnt_clr", cnt_clr, e_cnt_clr);
        check("adj_sec", adj_sec, e_adj_sec);
        check("adj_min", adj_min, e_adj_min);
        check("running", running, e_running);
        check("blink",   blink,   e_blink);
`ifdef STOPWATCH_LAP_EN
        check("lap_hold", lap_hold, e_lap);
`endif
    endtask

    initial begin
        int c0, t1, t2, t, n, r, a, s1, s2, s;

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_running", running, 0);
        check("rst_blink", blink, 1);

        // Held pause button: one RUN entry, ticks at +10 and +20
        btn_pause = 1'b1;
        step();
        c0 = cyc; t1 = -1; t2 = -1;
        for (int i = 1; i <= 25; i++) begin
            if (i == 5) btn_pause = 1'b0;
            step();
            if (cnt_en === 1'b1) begin
                if (t1 < 0) t1 = cyc; else if (t2 < 0) t2 = cyc;
            end
        end
        check("first_tick_lat", t1 - c0, SEC_CYC);
        check("second_tick_lat", t2 - c0, 2 * SEC_CYC);
        check("held_run", running, 1);

        // Pause 4 cycles after a tick, wait 20, resume: next tick after 6
        t = -1;
        for (int i = 0; i < 15 && t < 0; i++) begin
            step();
            if (cnt_en === 1'b1) t = cyc;
        end
        check("tick_found", t >= 0, 1);
        repeat (3) step();
        btn_pause = 1'b1;
        step();
        btn_pause = 1'b0;
        n = 0;
        repeat (20) begin
            step();
            if (cnt_en === 1'b1) n++;
        end
        check("paused_ticks", n, 0);
        btn_pause = 1'b1;
        step();
        r = cyc;
        btn_pause = 1'b0;
        t = -1;
        for (int i = 0; i < 15 && t < 0; i++) begin
            step();
            if (cnt_en === 1'b1) t = cyc;
        end
        check("resume_lat", t - r, SEC_CYC - 4);

        // at_max in RUN forces PAUSE; resume refused while at_max
        at_max = 1'b1;
        step();
        check("atmax_pause", running, 0);
        n = 0;
        btn_pause = 1'b1;
        step();
        if (cnt_en === 1'b1) n++;
        btn_pause = 1'b0;
        repeat (12) begin
            step();
            if (cnt_en === 1'b1) n++;
        end
        check("atmax_no_resume", running, 0);
        check("atmax_ticks", n, 0);
        at_max = 1'b0;

        // Adjust mode: seconds pulses at +5/+10, sel change restarts count
        adj = 1'b1; sel = 1'b0;
        step();
        a = cyc; s1 = -1; s2 = -1; n = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (adj_sec === 1'b1) begin
                if (s1 < 0) s1 = cyc; else if (s2 < 0) s2 = cyc;
            end
            if (adj_min === 1'b1) n++;
        end
        check("adj_sec_lat1", s1 - a, ADJ_CYC);
        check("adj_sec_lat2", s2 - a, 2 * ADJ_CYC);
        check("adj_min_none", n, 0);
        sel = 1'b1;
        step();
        s = cyc; t = -1;
        for (int i = 0; i < 10 && t < 0; i++) begin
            step();
            if (adj_min === 1'b1) t = cyc;
        end
        check("adj_min_lat", t - s, ADJ_CYC);
        adj = 1'b0;
        step();
        check("adj_exit_blink", blink, 1);

        // Clear and pause edges together from RUN
        btn_pause = 1'b1;
        step();
        btn_pause = 1'b0;
        repeat (3) step();
        check("pre_clr_run", running, 1);
        btn_pause = 1'b1; btn_clr = 1'b1;
        step();
        check("clr_pulse", cnt_clr, 1);
        check("clr_idle", running, 0);
        btn_pause = 1'b0; btn_clr = 1'b0;
        step();
        check("clr_one_cycle", cnt_clr, 0);

`ifdef STOPWATCH_LAP_EN
        // Lap toggles hold in RUN, counting continues, pause drops hold
        btn_pause = 1'b1;
        step();
        btn_pause = 1'b0;
        btn_lap = 1'b1;
        step();
        btn_lap = 1'b0;
        check("lap_set", lap_hold, 1);
        t = -1;
        for (int i = 0; i < 15 && t < 0; i++) begin
            step();
            if (cnt_en === 1'b1) t = cyc;
        end
        check("lap_ticks_continue", t >= 0, 1);
        btn_pause = 1'b1;
        step();
        btn_pause = 1'b0;
        check("lap_cleared", lap_hold, 0);
`endif

        // Randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0)   btn_pause = ~btn_pause;
            if ($urandom_range(39) == 0)  btn_clr = ~btn_clr;
            if ($urandom_range(24) == 0)  adj = ~adj;
            if ($urandom_range(11) == 0)  sel = ~sel;
            if ($urandom_range(29) == 0)  at_max = ~at_max;
            if ($urandom_range(9) == 0)   btn_lap = ~btn_lap;
            rst = ($urandom_range(599) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch time-keeping counter (minutes 0–99, seconds 0–59, max 5999 total seconds). It converts raw button and switch levels into run, pause, clear and adjust commands. It generates the one-second count-enable pulse and the per-field adjust increment pulses that drive the counter. It sits between the board I/O synchronizers and the counter, and supplies a blink qualifier to the seven-segment display driver.

## Interface
- CLK_HZ, 100_000_000, system clock frequency; one-second tick period in cycles.
- ADJ_HZ, 2, rate of adjust increment pulses while in adjust mode.
- BLINK_HZ, 4, toggle rate of the blink qualifier in adjust mode.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_pause  in  1  synchronized level, pause/resume button.
- btn_clr  in  1  synchronized level, clear button.
- adj  in  1  synchronized level, adjust-mode switch.
- sel  in  1  adjust field select: 0 = seconds, 1 = minutes.
- at_max  in  1  counter is at 99:59 (5999 s).
- cnt_en  out  1  one-cycle pulse: advance counter by one second.
- cnt_clr  out  1  one-cycle pulse: clear counter to 00:00.
- adj_sec  out  1  one-cycle pulse: increment seconds field only (wrap 59→0, no carry).
- adj_min  out  1  one-cycle pulse: increment minutes field only (wrap 99→0).
- running  out  1  high in RUN.
- blink  out  1  display enable qualifier for the selected field.

## Operation
- The block does rising-edge detection on btn_pause and btn_clr using a registered previous value. Edge = level & ~prev. Held buttons produce exactly one event. The adj input is level-sensitive.
- States: IDLE, RUN, PAUSE, ADJ.
- Reset: state IDLE, dividers 0, edge registers 0. Every output is 0 except blink, which resets to 1.
- Event priority in one cycle: clear edge > pause edge > adj level > at_max.
- Clear edge, in any state: state goes to IDLE, cnt_clr pulses for one cycle, all dividers go to 0.
- Pause edge transitions:
  - IDLE → RUN.
  - RUN → PAUSE.
  - PAUSE → RUN, unless at_max is high, in which case the state stays PAUSE.
  - In ADJ the pause edge is ignored.
- adj = 1 in IDLE or PAUSE: state goes to ADJ. adj = 0 in ADJ: state goes to PAUSE. adj has no effect in RUN.
- RUN: the tick divider counts 0..CLK_HZ-1. At terminal count it wraps to 0 and cnt_en pulses, but only if at_max = 0. If at_max = 1 in RUN, the state goes to PAUSE and cnt_en is suppressed.
- PAUSE: the tick divider holds its value, so a resume continues the partial second. IDLE and ADJ hold the tick divider at 0.
- ADJ:
  - The adjust divider counts 0..CLK_HZ/ADJ_HZ-1. At terminal count it pulses adj_sec (sel = 0) or adj_min (sel = 1), never both.
  - A change of sel resets the adjust divider.
  - blink toggles every CLK_HZ/(2·BLINK_HZ) cycles. Outside ADJ, blink = 1.
- Divider widths are $clog2 of their terminal count + 1. All compares are unsigned.

## Timing
- A button edge sampled at cycle N changes the state and any related pulse at cycle N+1.
- Entering RUN from IDLE at cycle N gives the first cnt_en at cycle N+CLK_HZ.
- Entering ADJ at cycle N gives the first adjust pulse at cycle N+CLK_HZ/ADJ_HZ.
- All outputs are registered. No output is combinational from any input.
- Reset asserted mid-operation takes effect on the next edge. Pending pulses are dropped.
- Clear and pause edges in the same cycle: clear wins and state is IDLE. The pause edge is consumed, not deferred.

## Configuration
- STOPWATCH_LAP_EN defined:
  - Adds input btn_lap and output lap_hold.
  - A btn_lap edge in RUN toggles lap_hold. While lap_hold is high the display driver freezes the shown time, but counting continues.
  - lap_hold is cleared by reset, a clear edge, or leaving RUN.
  - The clear edge keeps priority over the lap edge.
- Not defined: the ports are absent and behaviour is as above.

## Structure
- Shared package stopwatch_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, ADJ),
  - MAX_TOTALSEC = 5999,
  - MAX_MIN = 99,
  - MAX_SEC = 59.
- One natural sub-module: stopwatch_pulse_div. It is a parameterized terminal-count divider with enable and sync clear, emitting a one-cycle pulse. It is instantiated for the tick, adjust and blink timing.

## Test plan
All scenarios use CLK_HZ=10, ADJ_HZ=2, BLINK_HZ=1.
- Reset, then btn_pause high for 5 cycles → one RUN entry only. cnt_en at cycles +10 and +20, running = 1.
- RUN, then pause edge 4 cycles after a tick, wait 20 cycles, then resume → no cnt_en while paused. Next cnt_en arrives 6 cycles after resume.
- RUN with at_max = 1 → PAUSE next cycle, cnt_en never asserts. Pause edge with at_max = 1 → stays in PAUSE.
- PAUSE, adj = 1, sel = 0 for 12 cycles → adj_sec at +5 and +10, adj_min never. Switching sel = 1 restarts the count, giving adj_min 5 cycles later. blink toggles every 5 cycles.
- Clear and pause edges in the same cycle from RUN → cnt_clr for one cycle, state IDLE, running = 0.
- With STOPWATCH_LAP_EN: lap edge in RUN → lap_hold = 1 and cnt_en continues. Pause edge → lap_hold = 0.
